reu_dma_seq: RTL and testbench

REU_DMA_SEQ -- requirements
Module: reu_dma_seq

---
 rtl/reu_dma_seq.sv | 171 +++++++++++++++++
 tb/tb_reu_dma_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reu_dma_seq.sv
`default_nettype none
// ============================================================================
// Module   : reu_dma_seq
// Brief    : REU DMA byte sequencer; walks C64/SDRAM accesses per transfer type.
// Revision : 1.0 - initial release
// ============================================================================
module reu_dma_seq (
    input  logic       PHI2,
    input  logic       Reset,
    input  logic       Execute,
    input  logic [1:0] XferType,
    input  logic       Length1,
    input  logic       BA,
    input  logic       RAMReady,
    input  logic       DataMatch,
    output logic       DMAn,
    output logic       CRD,
    output logic       CWR,
    output logic       RamRD,
    output logic       RamWR,
    output logic       LdC,
    output logic       LdR,
    output logic       IncCA,
    output logic       IncREUA,
    output logic       DecLen,
    output logic       XferEnd,
    output logic       SetEndOfBlock,
    output logic       SetVerifyErr
);

    localparam logic [1:0] C_XT_STASH  = 2'b00;
    localparam logic [1:0] C_XT_FETCH  = 2'b01;
    localparam logic [1:0] C_XT_SWAP   = 2'b10;
    localparam logic [1:0] C_XT_VERIFY = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_CRDS = 3'd2,
        S_CWRS = 3'd3,
        S_RRDS = 3'd4,
        S_RWRS = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] type_q, type_d;

    state_t     w_first;
    state_t     w_next;
    logic       w_done;
    logic       w_last;
    logic       w_verify_err;

    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        w_next        = S_IDLE;
        w_done        = 1'b0;
        w_last        = 1'b0;
        w_first       = (type_q == C_XT_FETCH) ? S_RRDS : S_CRDS;
        w_verify_err  = (type_q == C_XT_VERIFY) && !DataMatch;
        DMAn          = 1'b0;
        CRD           = 1'b0;
        CWR           = 1'b0;
        RamRD         = 1'b0;
        RamWR         = 1'b0;
        LdC           = 1'b0;
        LdR           = 1'b0;
        IncCA         = 1'b0;
        IncREUA       = 1'b0;
        DecLen        = 1'b0;
        XferEnd       = 1'b0;
        SetEndOfBlock = 1'b0;
        SetVerifyErr  = 1'b0;

        case (state_q)
            S_IDLE: begin
                DMAn = 1'b1;
                if (Execute) begin
                    type_d  = XferType;
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (BA) begin
                    state_d = w_first;
                end
            end
            S_CRDS: begin
                CRD    = BA;
                LdC    = BA;
                w_done = BA;
                w_next = (type_q == C_XT_STASH) ? S_RWRS : S_RRDS;
            end
            S_CWRS: begin
                // CWRS always closes a byte (fetch and swap both end here)
                CWR    = BA;
                w_done = BA;
                w_last = 1'b1;
            end
            S_RRDS: begin
                RamRD  = 1'b1;
                LdR    = RAMReady;
                w_done = RAMReady;
                w_last = (type_q == C_XT_VERIFY);
                w_next = (type_q == C_XT_SWAP) ? S_RWRS : S_CWRS;
            end
            S_RWRS: begin
                RamWR  = 1'b1;
                w_done = RAMReady;
                w_last = (type_q == C_XT_STASH);
                w_next = S_CWRS;
            end
            default: begin
                DMAn    = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        if (w_done) begin
            if (w_last) begin
                IncCA   = 1'b1;
                IncREUA = 1'b1;
                if (w_verify_err) begin
                    SetVerifyErr  = 1'b1;
                    XferEnd       = 1'b1;
                    SetEndOfBlock = Length1;
                    state_d       = S_IDLE;
                end else if (Length1) begin
                    XferEnd       = 1'b1;
                    SetEndOfBlock = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    DecLen  = 1'b1;
                    state_d = w_first;
                end
            end else begin
                state_d = w_next;
            end
        end

        // Outputs are quiet for the whole reset cycle, not just after it
        if (Reset) begin
            DMAn          = 1'b1;
            CRD           = 1'b0;
            CWR           = 1'b0;
            RamRD         = 1'b0;
            RamWR         = 1'b0;
            LdC           = 1'b0;
            LdR           = 1'b0;
            IncCA         = 1'b0;
            IncREUA       = 1'b0;
            DecLen        = 1'b0;
            XferEnd       = 1'b0;
            SetEndOfBlock = 1'b0;
            SetVerifyErr  = 1'b0;
        end
    end

    always_ff @(negedge PHI2) begin
        if (Reset) begin
            state_q <= S_IDLE;
            type_q  <= C_XT_STASH;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reu_dma_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_reu_dma_seq
// Brief    : Directed cycle-by-cycle bench for reu_dma_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reu_dma_seq;

    logic       PHI2;
    logic       Reset;
    logic       Execute;
    logic [1:0] XferType;
    logic       Length1;
    logic       BA;
    logic       RAMReady;
    logic       DataMatch;
    logic       DMAn, CRD, CWR, RamRD, RamWR, LdC, LdR;
    logic       IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock, SetVerifyErr;
    logic [12:0] obs;

    int total = 0;
    int bad   = 0;

    reu_dma_seq u_dut (
        .PHI2          (PHI2),
        .Reset         (Reset),
        .Execute       (Execute),
        .XferType      (XferType),
        .Length1       (Length1),
        .BA            (BA),
        .RAMReady      (RAMReady),
        .DataMatch     (DataMatch),
        .DMAn          (DMAn),
        .CRD           (CRD),
        .CWR           (CWR),
        .RamRD         (RamRD),
        .RamWR         (RamWR),
        .LdC           (LdC),
        .LdR           (LdR),
        .IncCA         (IncCA),
        .IncREUA       (IncREUA),
        .DecLen        (DecLen),
        .XferEnd       (XferEnd),
        .SetEndOfBlock (SetEndOfBlock),
        .SetVerifyErr  (SetVerifyErr)
    );

    assign obs = {DMAn, CRD, LdC, CWR, RamRD, LdR, RamWR,
                  IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock, SetVerifyErr};

    initial PHI2 = 1'b1;
    always #5 PHI2 = ~PHI2;

    // Input vector: {Reset, Execute, XferType[1:0], Length1, BA, RAMReady, DataMatch}
    localparam logic [7:0] I_RST    = 8'h80;
    localparam logic [7:0] I_EXE    = 8'h40;
    localparam logic [7:0] I_FETCH  = 8'h10;
    localparam logic [7:0] I_SWAP   = 8'h20;
    localparam logic [7:0] I_VERIFY = 8'h30;
    localparam logic [7:0] I_L1     = 8'h08;
    localparam logic [7:0] I_BA     = 8'h04;
    localparam logic [7:0] I_RR     = 8'h02;
    localparam logic [7:0] I_DM     = 8'h01;

    localparam logic [12:0] E_NONE = 13'h0000;
    localparam logic [12:0] E_DMAN = 13'h1000;
    localparam logic [12:0] E_CRD  = 13'h0800;
    localparam logic [12:0] E_LDC  = 13'h0400;
    localparam logic [12:0] E_CWR  = 13'h0200;
    localparam logic [12:0] E_RRD  = 13'h0100;
    localparam logic [12:0] E_LDR  = 13'h0080;
    localparam logic [12:0] E_RWR  = 13'h0040;
    localparam logic [12:0] E_INC  = 13'h0030;
    localparam logic [12:0] E_DEC  = 13'h0008;
    localparam logic [12:0] E_XE   = 13'h0004;
    localparam logic [12:0] E_EOB  = 13'h0002;
    localparam logic [12:0] E_VE   = 13'h0001;

    task automatic drive(input logic [7:0] v);
        Reset     = v[7];
        Execute   = v[6];
        XferType  = v[5:4];
        Length1   = v[3];
        BA        = v[2];
        RAMReady  = v[1];
        DataMatch = v[0];
    endtask

    task automatic test_reset;
        logic [7:0]  vin  [4];
        logic [12:0] vexp [4];
        vin  = '{I_RST, I_RST | I_EXE | I_FETCH, 8'h00, 8'h00};
        vexp = '{E_DMAN, E_DMAN, E_DMAN, E_DMAN};
        for (int i = 0; i < 4; i++) begin
            drive(vin[i]);
            @(posedge PHI2);
            total++;
            if (obs !== vexp[i]) begin
                bad++;
                $display("FAIL reset cyc%0d actual=%b required=%b", i, obs, vexp[i]);
            end
            @(negedge PHI2); #1;
        end
    endtask

    task automatic test_stash;
        logic [7:0]  vin  [7];
        logic [12:0] vexp [7];
        vin  = '{I_EXE | I_BA | I_RR, I_BA | I_RR, I_BA | I_RR, I_BA | I_RR,
                 I_L1 | I_BA | I_RR, I_L1 | I_BA | I_RR, I_BA | I_RR};
        vexp = '{E_DMAN, E_NONE, E_CRD | E_LDC, E_RWR | E_INC | E_DEC,
                 E_CRD | E_LDC, E_RWR | E_INC | E_XE | E_EOB, E_DMAN};
        for (int i = 0; i < 7; i++) begin
            drive(vin[i]);
            @(posedge PHI2);
            total++;
            if (obs !== vexp[i]) begin
                bad++;
                $display("FAIL stash cyc%0d actual=%b required=%b", i, obs, vexp[i]);
            end
            @(negedge PHI2); #1;
        end
    endtask

    task automatic test_fetch;
        logic [7:0]  vin  [7];
        logic [12:0] vexp [7];
        vin  = '{I_EXE | I_FETCH | I_L1 | I_BA, I_FETCH | I_L1 | I_BA,
                 I_FETCH | I_L1 | I_BA, I_FETCH | I_L1 | I_BA,
                 I_FETCH | I_L1 | I_BA | I_RR, I_FETCH | I_L1 | I_BA,
                 I_FETCH | I_L1 | I_BA};
        vexp = '{E_DMAN, E_NONE, E_RRD, E_RRD, E_RRD | E_LDR,
                 E_CWR | E_INC | E_XE | E_EOB, E_DMAN};
        for (int i = 0; i < 7; i++) begin
            drive(vin[i]);
            @(posedge PHI2);
            total++;
            if (obs !== vexp[i]) begin
                bad++;
                $display("FAIL fetch cyc%0d actual=%b required=%b", i, obs, vexp[i]);
            end
            @(negedge PHI2); #1;
        end
    endtask

    task automatic test_ba_stall;
        logic [7:0]  vin  [9];
        logic [12:0] vexp [9];
        vin  = '{I_EXE | I_L1 | I_BA | I_RR, I_L1 | I_RR, I_L1 | I_BA | I_RR,
                 I_EXE | I_FETCH | I_L1 | I_RR, I_L1 | I_RR, I_L1 | I_RR,
                 I_L1 | I_BA | I_RR, I_L1 | I_BA | I_RR, I_L1 | I_BA | I_RR};
        vexp = '{E_DMAN, E_NONE, E_NONE, E_NONE, E_NONE, E_NONE,
                 E_CRD | E_LDC, E_RWR | E_INC | E_XE | E_EOB, E_DMAN};
        for (int i = 0; i < 9; i++) begin
            drive(vin[i]);
            @(posedge PHI2);
            total++;
            if (obs !== vexp[i]) begin
                bad++;
                $display("FAIL ba_stall cyc%0d actual=%b required=%b", i, obs, vexp[i]);
            end
            @(negedge PHI2); #1;
        end
    endtask

    task automatic test_verify_err;
        logic [7:0]  vin  [5];
        logic [12:0] vexp [5];
        vin  = '{I_EXE | I_VERIFY | I_BA | I_RR, I_VERIFY | I_BA | I_RR,
                 I_VERIFY | I_BA | I_RR, I_VERIFY | I_BA | I_RR, I_BA | I_RR};
        vexp = '{E_DMAN, E_NONE, E_CRD | E_LDC,
                 E_RRD | E_LDR | E_INC | E_XE | E_VE, E_DMAN};
        for (int i = 0; i < 5; i++) begin
            drive(vin[i]);
            @(posedge PHI2);
            total++;
            if (obs !== vexp[i]) begin
                bad++;
                $display("FAIL verify_err cyc%0d actual=%b required=%b", i, obs, vexp[i]);
            end
            @(negedge PHI2); #1;
        end
    endtask

    task automatic test_verify_match;
        logic [7:0]  vin  [7];
        logic [12:0] vexp [7];
        vin  = '{I_EXE | I_VERIFY | I_BA | I_RR | I_DM, I_VERIFY | I_BA | I_RR | I_DM,
                 I_VERIFY | I_BA | I_RR | I_DM, I_VERIFY | I_BA | I_RR | I_DM,
                 I_VERIFY | I_L1 | I_BA | I_RR, I_VERIFY | I_L1 | I_BA | I_RR,
                 I_BA | I_RR};
        vexp = '{E_DMAN, E_NONE, E_CRD | E_LDC, E_RRD | E_LDR | E_INC | E_DEC,
                 E_CRD | E_LDC, E_RRD | E_LDR | E_INC | E_XE | E_EOB | E_VE, E_DMAN};
        for (int i = 0; i < 7; i++) begin
            drive(vin[i]);
            @(posedge PHI2);
            total++;
            if (obs !== vexp[i]) begin
                bad++;
                $display("FAIL verify_match cyc%0d actual=%b required=%b", i, obs, vexp[i]);
            end
            @(negedge PHI2); #1;
        end
    endtask

    task automatic test_swap;
        logic [7:0]  vin  [8];
        logic [12:0] vexp [8];
        vin  = '{I_EXE | I_SWAP | I_L1 | I_BA | I_RR, I_SWAP | I_L1 | I_BA | I_RR,
                 I_SWAP | I_L1 | I_BA | I_RR, I_SWAP | I_L1 | I_BA | I_RR,
                 I_SWAP | I_L1 | I_BA | I_RR, I_SWAP | I_L1 | I_RR,
                 I_SWAP | I_L1 | I_BA | I_RR, I_BA | I_RR};
        vexp = '{E_DMAN, E_NONE, E_CRD | E_LDC, E_RRD | E_LDR, E_RWR, E_NONE,
                 E_CWR | E_INC | E_XE | E_EOB, E_DMAN};
        for (int i = 0; i < 8; i++) begin
            drive(vin[i]);
            @(posedge PHI2);
            total++;
            if (obs !== vexp[i]) begin
                bad++;
                $display("FAIL swap cyc%0d actual=%b required=%b", i, obs, vexp[i]);
            end
            @(negedge PHI2); #1;
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0]  vin  [10];
        logic [12:0] vexp [10];
        vin  = '{I_EXE | I_BA | I_RR, I_BA | I_RR, I_BA | I_RR, I_RST | I_BA | I_RR,
                 I_BA | I_RR, I_EXE | I_FETCH | I_L1 | I_BA | I_RR,
                 I_FETCH | I_L1 | I_BA | I_RR, I_FETCH | I_L1 | I_BA | I_RR,
                 I_FETCH | I_L1 | I_BA | I_RR, I_BA | I_RR};
        vexp = '{E_DMAN, E_NONE, E_CRD | E_LDC, E_DMAN, E_DMAN, E_DMAN, E_NONE,
                 E_RRD | E_LDR, E_CWR | E_INC | E_XE | E_EOB, E_DMAN};
        for (int i = 0; i < 10; i++) begin
            drive(vin[i]);
            @(posedge PHI2);
            total++;
            if (obs !== vexp[i]) begin
                bad++;
                $display("FAIL reset_mid cyc%0d actual=%b required=%b", i, obs, vexp[i]);
            end
            @(negedge PHI2); #1;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  vin  [10];
        logic [12:0] vexp [10];
        vin  = '{I_EXE | I_FETCH | I_L1 | I_BA | I_RR, I_EXE | I_FETCH | I_L1 | I_BA | I_RR,
                 I_EXE | I_FETCH | I_L1 | I_BA | I_RR, I_EXE | I_L1 | I_BA | I_RR,
                 I_EXE | I_L1 | I_BA | I_RR, I_BA | I_RR, I_BA | I_RR, I_BA,
                 I_L1 | I_BA | I_RR, I_BA | I_RR};
        vexp = '{E_DMAN, E_NONE, E_RRD | E_LDR, E_CWR | E_INC | E_XE | E_EOB,
                 E_DMAN, E_NONE, E_CRD | E_LDC, E_RWR,
                 E_RWR | E_INC | E_XE | E_EOB, E_DMAN};
        for (int i = 0; i < 10; i++) begin
            drive(vin[i]);
            @(posedge PHI2);
            total++;
            if (obs !== vexp[i]) begin
                bad++;
                $display("FAIL back_to_back cyc%0d actual=%b required=%b", i, obs, vexp[i]);
            end
            @(negedge PHI2); #1;
        end
    endtask

    initial begin
        drive(I_RST);
        @(negedge PHI2); #1;
        test_reset();
        test_stash();
        test_fetch();
        test_ba_stall();
        test_verify_err();
        test_verify_match();
        test_swap();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
